// File: rtl/axi_lite_arbiter2.sv
// Two-port AXI-lite arbiter: s0/s1 share one downstream slave m, one transaction in flight,
// round-robin between ports and read-before-write within a port.
module axi_lite_arbiter2 #(
    parameter int ADDR_WIDTH = 64,
    parameter int DATA_WIDTH = 64
) (
    input  logic                    clk,
    input  logic                    rstn,
    // upstream port 0
    input  logic [ADDR_WIDTH-1:0]   s0_awaddr,
    input  logic                    s0_awvalid,
    output logic                    s0_awready,
    input  logic [DATA_WIDTH-1:0]   s0_wdata,
    input  logic [DATA_WIDTH/8-1:0] s0_wstrb,
    input  logic                    s0_wvalid,
    output logic                    s0_wready,
    output logic [1:0]              s0_bresp,
    output logic                    s0_bvalid,
    input  logic                    s0_bready,
    input  logic [ADDR_WIDTH-1:0]   s0_araddr,
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    output logic [DATA_WIDTH-1:0]   s0_rdata,
    output logic [1:0]              s0_rresp,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    // upstream port 1
    input  logic [ADDR_WIDTH-1:0]   s1_awaddr,
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [DATA_WIDTH-1:0]   s1_wdata,
    input  logic [DATA_WIDTH/8-1:0] s1_wstrb,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    output logic [1:0]              s1_bresp,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,
    input  logic [ADDR_WIDTH-1:0]   s1_araddr,
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    output logic [DATA_WIDTH-1:0]   s1_rdata,
    output logic [1:0]              s1_rresp,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    // downstream port
    output logic [ADDR_WIDTH-1:0]   m_awaddr,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [DATA_WIDTH-1:0]   m_wdata,
    output logic [DATA_WIDTH/8-1:0] m_wstrb,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    input  logic [1:0]              m_bresp,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    output logic [ADDR_WIDTH-1:0]   m_araddr,
    output logic                    m_arvalid,
    input  logic                    m_arready,
    input  logic [DATA_WIDTH-1:0]   m_rdata,
    input  logic [1:0]              m_rresp,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    // status
    output logic                    busy,
    output logic [1:0]              grant
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP} state_t;

    state_t     state, state_nxt;
    logic [1:0] grant_nxt;
    logic       last_grant, last_grant_nxt;   // 0 = s0, 1 = s1
    logic       aw_done, aw_done_nxt;
    logic       w_done, w_done_nxt;

    logic       sel;
    logic       req0, req1, win1;
    logic       aw_hs, w_hs;
    logic       fwd_awready, fwd_wready, fwd_bvalid, fwd_arready, fwd_rvalid;
    logic       g_awvalid, g_wvalid, g_bready, g_arvalid, g_rready;

    assign sel  = grant[1];
    assign busy = (state != IDLE);

    // A write request needs both AW and W presented; a lone half is not a request.
    assign req0 = s0_arvalid | (s0_awvalid & s0_wvalid);
    assign req1 = s1_arvalid | (s1_awvalid & s1_wvalid);
    assign win1 = req1 & (~req0 | ~last_grant);

    assign g_awvalid = sel ? s1_awvalid : s0_awvalid;
    assign g_wvalid  = sel ? s1_wvalid  : s0_wvalid;
    assign g_bready  = sel ? s1_bready  : s0_bready;
    assign g_arvalid = sel ? s1_arvalid : s0_arvalid;
    assign g_rready  = sel ? s1_rready  : s0_rready;

    assign m_awaddr = sel ? s1_awaddr : s0_awaddr;
    assign m_wdata  = sel ? s1_wdata  : s0_wdata;
    assign m_wstrb  = sel ? s1_wstrb  : s0_wstrb;
    assign m_araddr = sel ? s1_araddr : s0_araddr;

    assign s0_rdata = m_rdata;
    assign s0_rresp = m_rresp;
    assign s0_bresp = m_bresp;
    assign s1_rdata = m_rdata;
    assign s1_rresp = m_rresp;
    assign s1_bresp = m_bresp;

    assign s0_awready = grant[0] & fwd_awready;
    assign s0_wready  = grant[0] & fwd_wready;
    assign s0_bvalid  = grant[0] & fwd_bvalid;
    assign s0_arready = grant[0] & fwd_arready;
    assign s0_rvalid  = grant[0] & fwd_rvalid;
    assign s1_awready = grant[1] & fwd_awready;
    assign s1_wready  = grant[1] & fwd_wready;
    assign s1_bvalid  = grant[1] & fwd_bvalid;
    assign s1_arready = grant[1] & fwd_arready;
    assign s1_rvalid  = grant[1] & fwd_rvalid;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state      <= IDLE;
            grant      <= '0;
            last_grant <= 1'b1;
            aw_done    <= 1'b0;
            w_done     <= 1'b0;
        end else begin
            state      <= state_nxt;
            grant      <= grant_nxt;
            last_grant <= last_grant_nxt;
            aw_done    <= aw_done_nxt;
            w_done     <= w_done_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        grant_nxt      = grant;
        last_grant_nxt = last_grant;
        aw_done_nxt    = aw_done;
        w_done_nxt     = w_done;
        m_awvalid      = 1'b0;
        m_wvalid       = 1'b0;
        m_bready       = 1'b0;
        m_arvalid      = 1'b0;
        m_rready       = 1'b0;
        fwd_awready    = 1'b0;
        fwd_wready     = 1'b0;
        fwd_bvalid     = 1'b0;
        fwd_arready    = 1'b0;
        fwd_rvalid     = 1'b0;
        aw_hs          = 1'b0;
        w_hs           = 1'b0;
        case (state)
            IDLE: begin
                if (req0 | req1) begin
                    grant_nxt      = win1 ? 2'b10 : 2'b01;
                    last_grant_nxt = win1;
                    state_nxt      = (win1 ? s1_arvalid : s0_arvalid) ? RD_ADDR : WR_REQ;
                end
            end
            RD_ADDR: begin
                m_arvalid   = g_arvalid;
                fwd_arready = m_arready;
                if (g_arvalid & m_arready) state_nxt = RD_DATA;
            end
            RD_DATA: begin
                fwd_rvalid = m_rvalid;
                m_rready   = g_rready;
                if (m_rvalid & g_rready) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            WR_REQ: begin
                // Each channel is masked off once its own handshake has been recorded.
                m_awvalid   = g_awvalid & ~aw_done;
                fwd_awready = m_awready & ~aw_done;
                m_wvalid    = g_wvalid & ~w_done;
                fwd_wready  = m_wready & ~w_done;
                aw_hs       = g_awvalid & ~aw_done & m_awready;
                w_hs        = g_wvalid & ~w_done & m_wready;
                if (aw_hs) aw_done_nxt = 1'b1;
                if (w_hs)  w_done_nxt  = 1'b1;
                if ((aw_done | aw_hs) & (w_done | w_hs)) begin
                    state_nxt   = WR_RESP;
                    aw_done_nxt = 1'b0;
                    w_done_nxt  = 1'b0;
                end
            end
            WR_RESP: begin
                fwd_bvalid = m_bvalid;
                m_bready   = g_bready;
                if (m_bvalid & g_bready) begin
                    state_nxt = IDLE;
                    grant_nxt = '0;
                end
            end
            default: begin
                state_nxt = IDLE;
                grant_nxt = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_axi_lite_arbiter2.sv
// Directed bench for axi_lite_arbiter2: arbitration order, channel forwarding, split write
// handshakes, round-robin fairness and mid-transaction reset.
module tb_axi_lite_arbiter2;

    localparam int AW = 64;
    localparam int DW = 64;
    localparam int SW = DW / 8;

    localparam logic [AW-1:0] A0  = 64'h0000_0000_1000_0040;
    localparam logic [AW-1:0] A1  = 64'h0000_0000_2000_0080;
    localparam logic [AW-1:0] WA1 = 64'h0000_0000_3000_00C0;
    localparam logic [DW-1:0] D0  = 64'hDEAD_BEEF_0123_4567;
    localparam logic [DW-1:0] WD1 = 64'hCAFE_F00D_89AB_CDEF;

    logic clk = 1'b0;
    logic rstn;

    logic [AW-1:0] s0_awaddr, s1_awaddr, s0_araddr, s1_araddr, m_awaddr, m_araddr;
    logic [DW-1:0] s0_wdata, s1_wdata, s0_rdata, s1_rdata, m_wdata, m_rdata;
    logic [SW-1:0] s0_wstrb, s1_wstrb, m_wstrb;
    logic [1:0]    s0_bresp, s1_bresp, s0_rresp, s1_rresp, m_bresp, m_rresp;
    logic s0_awvalid, s0_awready, s0_wvalid, s0_wready, s0_bvalid, s0_bready;
    logic s0_arvalid, s0_arready, s0_rvalid, s0_rready;
    logic s1_awvalid, s1_awready, s1_wvalid, s1_wready, s1_bvalid, s1_bready;
    logic s1_arvalid, s1_arready, s1_rvalid, s1_rready;
    logic m_awvalid, m_awready, m_wvalid, m_wready, m_bvalid, m_bready;
    logic m_arvalid, m_arready, m_rvalid, m_rready;
    logic busy;
    logic [1:0] grant;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    axi_lite_arbiter2 #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rstn(rstn),
        .s0_awaddr(s0_awaddr), .s0_awvalid(s0_awvalid), .s0_awready(s0_awready),
        .s0_wdata(s0_wdata), .s0_wstrb(s0_wstrb), .s0_wvalid(s0_wvalid), .s0_wready(s0_wready),
        .s0_bresp(s0_bresp), .s0_bvalid(s0_bvalid), .s0_bready(s0_bready),
        .s0_araddr(s0_araddr), .s0_arvalid(s0_arvalid), .s0_arready(s0_arready),
        .s0_rdata(s0_rdata), .s0_rresp(s0_rresp), .s0_rvalid(s0_rvalid), .s0_rready(s0_rready),
        .s1_awaddr(s1_awaddr), .s1_awvalid(s1_awvalid), .s1_awready(s1_awready),
        .s1_wdata(s1_wdata), .s1_wstrb(s1_wstrb), .s1_wvalid(s1_wvalid), .s1_wready(s1_wready),
        .s1_bresp(s1_bresp), .s1_bvalid(s1_bvalid), .s1_bready(s1_bready),
        .s1_araddr(s1_araddr), .s1_arvalid(s1_arvalid), .s1_arready(s1_arready),
        .s1_rdata(s1_rdata), .s1_rresp(s1_rresp), .s1_rvalid(s1_rvalid), .s1_rready(s1_rready),
        .m_awaddr(m_awaddr), .m_awvalid(m_awvalid), .m_awready(m_awready),
        .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_wvalid(m_wvalid), .m_wready(m_wready),
        .m_bresp(m_bresp), .m_bvalid(m_bvalid), .m_bready(m_bready),
        .m_araddr(m_araddr), .m_arvalid(m_arvalid), .m_arready(m_arready),
        .m_rdata(m_rdata), .m_rresp(m_rresp), .m_rvalid(m_rvalid), .m_rready(m_rready),
        .busy(busy), .grant(grant)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] expg;
        int served0, served1;

        rstn = 1'b0;
        s0_awaddr = '0; s0_awvalid = 0; s0_wdata = '0; s0_wstrb = '0; s0_wvalid = 0;
        s0_bready = 1; s0_araddr = A0; s0_arvalid = 0; s0_rready = 1;
        s1_awaddr = WA1; s1_awvalid = 0; s1_wdata = WD1; s1_wstrb = 8'h0F; s1_wvalid = 0;
        s1_bready = 1; s1_araddr = A1; s1_arvalid = 0; s1_rready = 1;
        m_awready = 0; m_wready = 0; m_bresp = 2'b00; m_bvalid = 0;
        m_arready = 0; m_rdata = '0; m_rresp = 2'b00; m_rvalid = 0;

        // Reset state
        tick(); tick();
        rstn = 1'b1;
        #1;
        chk("rst_grant", grant, 2'b00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_m_arvalid", m_arvalid, 1'b0);
        chk("rst_m_awvalid", m_awvalid, 1'b0);

        // Simultaneous reads after reset: s0 wins the first tie
        s0_arvalid = 1; s1_arvalid = 1;
        #1;
        chk("arb_cycle_grant", grant, 2'b00);
        chk("arb_cycle_s0_arready", s0_arready, 1'b0);
        tick();
        chk("tie_grant", grant, 2'b01);
        chk("tie_busy", busy, 1'b1);
        chk("tie_m_arvalid", m_arvalid, 1'b1);
        chk("tie_m_araddr", m_araddr, A0);
        chk("rdaddr_m_rready", m_rready, 1'b0);
        m_arready = 1;
        #1;
        chk("s0_arready_fwd", s0_arready, 1'b1);
        chk("s1_arready_blocked", s1_arready, 1'b0);
        tick();
        s0_arvalid = 0; m_arready = 0;
        m_rvalid = 1; m_rdata = D0; m_rresp = 2'b10;
        #1;
        chk("rddata_m_arvalid", m_arvalid, 1'b0);
        chk("s0_rvalid", s0_rvalid, 1'b1);
        chk("s0_rdata", s0_rdata, D0);
        chk("s0_rresp", s0_rresp, 2'b10);
        chk("s1_rvalid_blocked", s1_rvalid, 1'b0);
        chk("m_rready", m_rready, 1'b1);
        tick();
        m_rvalid = 0;
        chk("after_r_idle_grant", grant, 2'b00);
        chk("after_r_idle_busy", busy, 1'b0);
        tick();
        chk("s1_served_grant", grant, 2'b10);
        chk("s1_m_araddr", m_araddr, A1);
        m_arready = 1;
        tick();
        s1_arvalid = 0; m_arready = 0; m_rvalid = 1;
        #1;
        chk("s1_rvalid", s1_rvalid, 1'b1);
        chk("s0_rvalid_blocked", s0_rvalid, 1'b0);
        tick();
        m_rvalid = 0;

        // s1 write, AW accepted one cycle before W
        s1_awvalid = 1; s1_wvalid = 1;
        tick();
        chk("wr_grant", grant, 2'b10);
        chk("wr_m_awvalid", m_awvalid, 1'b1);
        chk("wr_m_wvalid", m_wvalid, 1'b1);
        chk("wr_m_awaddr", m_awaddr, WA1);
        chk("wr_m_wdata", m_wdata, WD1);
        chk("wr_m_wstrb", m_wstrb, 8'h0F);
        m_awready = 1;
        #1;
        chk("s1_awready", s1_awready, 1'b1);
        chk("s1_wready_low", s1_wready, 1'b0);
        chk("s0_awready_blocked", s0_awready, 1'b0);
        tick();
        m_awready = 0;
        #1;
        chk("aw_done_masks_awvalid", m_awvalid, 1'b0);
        chk("still_wreq_m_wvalid", m_wvalid, 1'b1);
        m_wready = 1;
        #1;
        chk("s1_wready", s1_wready, 1'b1);
        tick();
        s1_awvalid = 0; s1_wvalid = 0; m_wready = 0;
        m_bvalid = 1; m_bresp = 2'b01;
        #1;
        chk("wresp_m_wvalid", m_wvalid, 1'b0);
        chk("s1_bvalid", s1_bvalid, 1'b1);
        chk("s1_bresp", s1_bresp, 2'b01);
        chk("s0_bvalid_blocked", s0_bvalid, 1'b0);
        chk("m_bready", m_bready, 1'b1);
        tick();
        m_bvalid = 0;
        chk("after_b_grant", grant, 2'b00);

        // s0 read and write together: read first, write two cycles after R handshake
        s0_arvalid = 1; s0_awvalid = 1; s0_wvalid = 1; s0_awaddr = A0 + 64'h8;
        tick();
        chk("rw_read_first_grant", grant, 2'b01);
        chk("rw_read_first_arvalid", m_arvalid, 1'b1);
        chk("rw_read_first_awvalid", m_awvalid, 1'b0);
        m_arready = 1;
        tick();
        s0_arvalid = 0; m_arready = 0; m_rvalid = 1;
        tick();
        m_rvalid = 0;
        chk("rw_gap_grant", grant, 2'b00);
        tick();
        chk("rw_write_grant", grant, 2'b01);
        chk("rw_write_awvalid", m_awvalid, 1'b1);
        chk("rw_write_awaddr", m_awaddr, A0 + 64'h8);
        m_awready = 1; m_wready = 1;
        tick();
        s0_awvalid = 0; s0_wvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 1;
        #1;
        chk("rw_s0_bvalid", s0_bvalid, 1'b1);
        tick();
        m_bvalid = 0;

        // Lone s1 awvalid is not a request while s0 reads
        s1_awvalid = 1; s1_wvalid = 0; s0_arvalid = 1;
        tick();
        chk("lone_aw_s0_grant", grant, 2'b01);
        m_arready = 1;
        tick();
        s0_arvalid = 0; m_arready = 0; m_rvalid = 1;
        #1;
        chk("lone_aw_s1_awready", s1_awready, 1'b0);
        tick();
        m_rvalid = 0;
        tick();
        chk("lone_aw_idle1", grant, 2'b00);
        tick();
        chk("lone_aw_idle2", grant, 2'b00);
        s1_wvalid = 1;
        tick();
        chk("lone_aw_then_w_grant", grant, 2'b10);
        m_awready = 1; m_wready = 1;
        tick();
        s1_awvalid = 0; s1_wvalid = 0; m_awready = 0; m_wready = 0; m_bvalid = 1;
        tick();
        m_bvalid = 0;

        // Continuous reads on both ports: grants must alternate, last grant was s1
        s0_arvalid = 1; s1_arvalid = 1;
        expg = 2'b01; served0 = 0; served1 = 0;
        for (int t = 0; t < 8; t++) begin
            for (int w = 0; w < 4 && grant == 2'b00; w++) tick();
            chk("rr_grant", grant, expg);
            chk("rr_araddr", m_araddr, (expg == 2'b01) ? A0 : A1);
            if (grant == 2'b01) served0++;
            if (grant == 2'b10) served1++;
            m_arready = 1;
            tick();
            m_arready = 0; m_rvalid = 1;
            tick();
            m_rvalid = 0;
            expg = {expg[0], expg[1]};
        end
        s0_arvalid = 0; s1_arvalid = 0;
        chk("rr_served0", served0, 4);
        chk("rr_served1", served1, 4);
        tick();

        // Reset during RD_DATA with no rvalid
        s0_arvalid = 1;
        tick();
        chk("rstmid_grant", grant, 2'b01);
        m_arready = 1;
        tick();
        m_arready = 0;
        rstn = 0;
        tick();
        chk("rstmid_grant_cleared", grant, 2'b00);
        chk("rstmid_busy", busy, 1'b0);
        chk("rstmid_m_arvalid", m_arvalid, 1'b0);
        chk("rstmid_m_rready", m_rready, 1'b0);
        chk("rstmid_s0_arready", s0_arready, 1'b0);
        chk("rstmid_s0_rvalid", s0_rvalid, 1'b0);
        rstn = 1;
        s1_arvalid = 1;
        tick();
        chk("post_rst_tie_s0", grant, 2'b01);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
